mic_sample_reader: RTL and testbench

Downstream consumer of the SPI microphone APB wrapper. On each wrapper interrupt it runs a single spec-compliant APB read of the 12-bit sample register and pushes the result into a first-word-fall-through circular buffer. It counts dropped samples and bus errors, and presents samples to the processing logic through a pop interface.

---
 rtl/mic_sample_reader.sv | 183 ++++++++++++++++++
 tb/tb_mic_sample_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_sample_reader.sv
// APB reader for the SPI microphone wrapper: one read per irq edge, samples
// land in a first-word-fall-through circular buffer with drop/error accounting.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; waiting for an irq edge or a pending request
// SETUP  | APB setup phase (PSEL=1, PENABLE=0), always one cycle
// ACCESS | APB access phase, waiting for PREADY or the wait timeout
module mic_sample_reader #(
    parameter int          DEPTH       = 16,
    parameter logic [11:0] SAMPLE_ADDR = 12'h000,
    parameter int          TIMEOUT     = 15
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     irq,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [11:0]              PADDR,
    output logic [31:0]              PWDATA,
    input  logic [31:0]              PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR,
    input  logic                     rd_en,
    output logic [11:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            pending, pending_n;
    logic            irq_q;
    logic [TW-1:0]   wait_cnt;

    logic [11:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;

    logic            irq_edge;
    logic            in_access;
    logic            timeout_hit;
    logic            xfer_done;
    logic            access_exit;
    logic            push_req;
    logic            bus_err;
    logic            pend_drop;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            fifo_drop;

    logic            unused_prdata;
    assign unused_prdata = ^PRDATA[31:12];

    assign irq_edge    = irq & ~irq_q;
    assign in_access   = (state == S_ACCESS);
    // Down-counter loaded in SETUP; terminal count in ACCESS means the
    // TIMEOUT-th access cycle has been reached without PREADY.
    assign timeout_hit = in_access && !PREADY && (wait_cnt == '0);
    assign xfer_done   = in_access && PREADY;
    assign access_exit = xfer_done || timeout_hit;
    assign push_req    = xfer_done && !PSLVERR;
    assign bus_err     = (xfer_done && PSLVERR) || timeout_hit;
    assign pend_drop   = irq_edge && pending && (state != S_IDLE);

    assign full      = (count == CW'(DEPTH));
    assign pop       = rd_en && rd_valid;
    assign push_ok   = push_req && (!full || pop);
    assign fifo_drop = push_req && full && !pop;

    assign PSEL     = (state != S_IDLE);
    assign PENABLE  = in_access;
    assign PWRITE   = 1'b0;
    assign PADDR    = SAMPLE_ADDR;
    assign PWDATA   = 32'h0;
    assign busy     = (state != S_IDLE);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            irq_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            irq_q   <= irq;
            if (state == S_SETUP) begin
                wait_cnt <= TW'(TIMEOUT - 1);
            end else if (in_access && !PREADY && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - TW'(1);
            end
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            S_IDLE: begin
                if (irq_edge || pending) begin
                    state_n   = S_SETUP;
                    pending_n = 1'b0;
                end
            end
            S_SETUP: begin
                state_n = S_ACCESS;
                if (irq_edge) begin
                    pending_n = 1'b1;
                end
            end
            S_ACCESS: begin
                if (access_exit) begin
                    // A pending request is consumed here; an edge arriving
                    // alongside it was already counted as a drop.
                    state_n   = (pending || irq_edge) ? S_SETUP : S_IDLE;
                    pending_n = 1'b0;
                end else if (irq_edge) begin
                    pending_n = 1'b1;
                end
            end
            default: begin
                state_n   = S_IDLE;
                pending_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= PRDATA[11:0];
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
            err_count  <= 8'h00;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
            if (fifo_drop || pend_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'h01;
                end
            end
            if (bus_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_mic_sample_reader.sv
// Directed and randomized checks of mic_sample_reader against a queue-based
// model of the sample buffer and its drop/error counters.
module tb_mic_sample_reader;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 15;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        irq;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        rd_en;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count, err_count;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;

    logic [11:0] mq[$];
    int          m_drop;
    int          m_err;
    bit          m_ovf;

    int          slv_wait = 0;
    bit          slv_hang = 1'b0;
    logic [7:0]  acc_cyc = 8'd0;

    mic_sample_reader #(
        .DEPTH      (DEPTH),
        .SAMPLE_ADDR(12'h000),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .irq       (irq),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overflow  (overflow),
        .drop_count(drop_count),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    // Slave responder: inserts slv_wait wait states, or never answers when hung.
    always @(posedge sysclk) begin
        if (PSEL && PENABLE && !PREADY) acc_cyc <= acc_cyc + 8'd1;
        else acc_cyc <= 8'd0;
    end
    assign PREADY = !slv_hang && (int'(acc_cyc) >= slv_wait);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat8(input int v);
        return (v > 255) ? 32'd255 : 32'(v);
    endfunction

    task automatic model_push(input logic [11:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        else begin
            m_drop++;
            m_ovf = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
        check({tag, ".drop_count"}, 32'(drop_count), sat8(m_drop));
        check({tag, ".err_count"}, 32'(err_count), sat8(m_err));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq   = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        mq.delete();
        m_drop = 0;
        m_err  = 0;
        m_ovf  = 1'b0;
    endtask

    // One irq pulse, then follow the transfer until the reader is idle again.
    task automatic run_xfer(input logic [31:0] d, input int w, input bit err,
                            input bit hang, output int n_acc);
        bit done;
        PRDATA   = d;
        slv_wait = w;
        PSLVERR  = err;
        slv_hang = hang;
        irq = 1'b1;
        @(negedge sysclk);
        irq   = 1'b0;
        n_acc = 0;
        done  = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (PSEL && PENABLE) n_acc++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
        check("xfer_completes", 32'(done), 32'd1);
        if (hang || err) m_err++;
        else model_push(d[11:0]);
        slv_hang = 1'b0;
        PSLVERR  = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge sysclk);
        rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          n_setup, n_access, first_idle;
        logic [31:0] d, d1, d2;
        bit          e;

        reset   = 1'b1;
        irq     = 1'b0;
        rd_en   = 1'b0;
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
        repeat (3) @(negedge sysclk);
        check("rst.psel", 32'(PSEL), 32'd0);
        check("rst.penable", 32'(PENABLE), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.pwrite", 32'(PWRITE), 32'd0);
        check("rst.paddr", 32'(PADDR), 32'h000);
        check("rst.pwdata", PWDATA, 32'h0);
        do_reset();
        check_state("rst");

        // Single irq, zero wait states
        PRDATA = 32'hFFFF_FABC;
        slv_wait = 0;
        irq = 1'b1;
        @(negedge sysclk);
        irq = 1'b0;
        check("single.setup_psel", 32'(PSEL), 32'd1);
        check("single.setup_penable", 32'(PENABLE), 32'd0);
        @(negedge sysclk);
        check("single.access_psel", 32'(PSEL), 32'd1);
        check("single.access_penable", 32'(PENABLE), 32'd1);
        @(negedge sysclk);
        check("single.done_psel", 32'(PSEL), 32'd0);
        model_push(12'hABC);
        check("single.rd_data", 32'(rd_data), 32'hABC);
        check_state("single");
        pop_one();
        check_state("single_pop");
        pop_one();
        check_state("empty_pop");

        // Wait states and timeout
        d = $urandom;
        run_xfer(d, 3, 1'b0, 1'b0, n);
        check("wait3.access_cycles", 32'(n), 32'd4);
        check_state("wait3");
        pop_one();
        run_xfer($urandom, 0, 1'b0, 1'b1, n);
        check("timeout.access_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout.psel_after", 32'(PSEL), 32'd0);
        check_state("timeout");

        // Slave errors and err_count saturation
        run_xfer($urandom, 0, 1'b1, 1'b0, n);
        check_state("slverr");
        for (int i = 0; i < 300; i++) run_xfer($urandom, 0, 1'b1, 1'b0, n);
        check("slverr.saturate", 32'(err_count), 32'hFF);
        check_state("slverr_sat");

        // Overflow with DEPTH samples plus one
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            d = ($urandom & 32'hFFFF_F000) | 32'(i);
            run_xfer(d, 0, 1'b0, 1'b0, n);
        end
        check("ovf.count", 32'(count), 32'd16);
        check("ovf.drop", 32'(drop_count), 32'd1);
        check_state("ovf");

        // Push and pop in the same cycle while full
        d = ($urandom & 32'hFFFF_F000) | 32'd18;
        PRDATA = d;
        irq = 1'b1;
        @(negedge sysclk);
        irq = 1'b0;
        @(negedge sysclk);
        rd_en = 1'b1;
        @(negedge sysclk);
        rd_en = 1'b0;
        void'(mq.pop_front());
        mq.push_back(d[11:0]);
        check("full_pushpop.count", 32'(count), 32'd16);
        check_state("full_pushpop");
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.rd_data", 32'(rd_data), 32'(mq[0]));
            pop_one();
        end
        check("drain.rd_valid", 32'(rd_valid), 32'd0);
        check_state("drain");

        // Edges during a transfer: one pending, one dropped
        do_reset();
        d1 = $urandom;
        d2 = $urandom;
        PRDATA   = d1;
        slv_wait = 4;
        n_setup = 0;
        n_access = 0;
        first_idle = -1;
        for (int k = 0; k <= 20; k++) begin
            if (k >= 1) begin
                if (PSEL && !PENABLE) n_setup++;
                if (PSEL && PENABLE) n_access++;
                if (!busy && first_idle < 0) first_idle = k;
            end
            irq = (k == 0 || k == 2 || k == 4);
            if (k == 7) PRDATA = d2;
            @(negedge sysclk);
        end
        irq = 1'b0;
        model_push(d1[11:0]);
        model_push(d2[11:0]);
        m_drop = 1;
        m_ovf  = 1'b1;
        check("b2b.setups", 32'(n_setup), 32'd2);
        check("b2b.accesses", 32'(n_access), 32'd10);
        check("b2b.first_idle", 32'(first_idle), 32'd13);
        check_state("b2b");
        pop_one();
        check_state("b2b_pop");
        slv_wait = 0;

        // Reset in the middle of ACCESS, irq held high across release
        run_xfer($urandom, 0, 1'b0, 1'b0, n);
        run_xfer($urandom, 0, 1'b1, 1'b0, n);
        slv_hang = 1'b1;
        irq = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        check("midrst.in_access", 32'(PENABLE), 32'd1);
        reset = 1'b1;
        @(negedge sysclk);
        mq.delete();
        m_drop = 0;
        m_err  = 0;
        m_ovf  = 1'b0;
        check("midrst.psel", 32'(PSEL), 32'd0);
        check("midrst.penable", 32'(PENABLE), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check_state("midrst");
        slv_hang = 1'b0;
        d = $urandom;
        PRDATA = d;
        reset = 1'b0;
        @(negedge sysclk);
        check("release.setup_psel", 32'(PSEL), 32'd1);
        check("release.setup_penable", 32'(PENABLE), 32'd0);
        repeat (2) @(negedge sysclk);
        model_push(d[11:0]);
        check_state("release");
        repeat (4) @(negedge sysclk);
        check("release.no_retrigger", 32'(busy), 32'd0);
        check_state("release_hold");
        irq = 1'b0;
        @(negedge sysclk);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 40; i++) begin
            e = ($urandom_range(0, 3) == 0);
            run_xfer($urandom, int'($urandom_range(0, 4)), e, 1'b0, n);
            if ($urandom_range(0, 2) == 0) pop_one();
            check_state("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
